rng_share_arb: RTL and testbench
================================

# rng_share_arb

Round-robin arbiter sharing one free-running 12-bit LFSR random stream among several noise-channel requesters. It throttles sample issue to a programmable rate and hands each granted requester exactly one fresh sample. It sits between `rng_lfsr_12bit` and the per-channel noise/wave units of the wave generator.

## Interface
Parameters:
- `N_REQ`, 4: number of requesters (2..8).
- `DW`, 12: sample width; matches the LFSR output.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  asynchronous, active-low reset.
- `i_en`  in  1  arbiter enable; low holds the divider and blocks grants.
- `i_div`  in  8  issue-rate divider; one issue slot every `i_div+1` cycles.
- `i_rng_data`  in  DW  LFSR output; new value every cycle.
- `i_req`  in  N_REQ  level request per channel.
- `o_gnt`  out  N_REQ  one-hot grant pulse, 1 cycle.
- `o_valid`  out  1  sample valid; coincident with `o_gnt`.
- `o_data`  out  DW  granted sample.
- `o_ptr`  out  clog2(N_REQ)  current round-robin start index (debug).

## Operation
- Divider `div_cnt` (8 bit):
  - `tick = i_en && (div_cnt >= i_div)`.
  - On tick, `div_cnt` returns to 0; otherwise it increments while `i_en` is high.
  - `i_en` low forces `div_cnt` to 0.
- Issue: on a cycle with tick and `|i_req`, the winner is the first set `i_req` bit searching upward from `ptr`, wrapping at `N_REQ-1`→0.
- On the next edge after an issue cycle:
  - `o_gnt` = one-hot winner and `o_valid` = 1.
  - `o_data` = `i_rng_data` sampled in the issue cycle, after the optional transform.
  - `ptr` = (winner+1) mod `N_REQ`.
- Tick with no request: slot is lost; ticks are not accumulated; `ptr` unchanged.
- No issue this cycle: `o_gnt` = 0, `o_valid` = 0, `o_data` holds its last value.
- Requests are level-sensitive:
  - A requester still asserting `i_req` after its grant competes again at the next tick, behind every other requester.
  - A request dropped before the tick is never granted.
- At most one grant per issue slot; each LFSR sample is given to at most one requester.
- `i_div` changes take effect immediately. If `div_cnt` is already ≥ the new value, the tick occurs in the current cycle.

## Timing
- Reset (async assert, synchronous-release behaviour up to the integrator): `o_gnt`=0, `o_valid`=0, `o_data`=0, `o_ptr`=0, `div_cnt`=0.
- Reset mid-grant clears the pulse immediately; `ptr` returns to 0.
- Latency: one cycle from the issue cycle (tick && request) to the `o_valid`/`o_gnt` pulse.
- `i_div`=0 with `i_en` high: a grant can occur every cycle; round-robin rotates every cycle under full load.
- Maximum throughput is 1 sample per `i_div+1` cycles regardless of the number of requesters.
- `i_en` falling during an issue cycle: that issue is not performed.
- `i_en` rising: first tick occurs when `div_cnt` reaches `i_div`, i.e. `i_div` cycles later. For `i_div`=0, the tick is in the same cycle `i_en` is first seen high.

## Configuration
- `RNG_ARB_DECORR_EN` defined: `o_data` = `i_rng_data` rotated left by (3·winner) mod `DW`. This decorrelates channels that receive consecutive LFSR states.
- Not defined: `o_data` = raw `i_rng_data`.
- Ports and timing are identical in both builds.

## Structure
- Package `rng_pkg`:
  - `RNG_DW` = 12.
  - Default `N_REQ` = 4.
  - Decorrelation rotate step `RNG_ROT_STEP` = 3.
  - Divider width `RNG_DIV_W` = 8.
- Sub-module `rng_rr_pick`: combinational round-robin picker. Inputs are `req` and `ptr`; outputs are a one-hot grant, the winner index and `any`. The top level holds all registers.

## Test plan
- Reset, then `i_en`=1, `i_div`=0, `i_req`=4'b1111 for 8 cycles → grants 0,1,2,3,0,1,2,3 on consecutive cycles; each `o_data` equals `i_rng_data` of the previous cycle (raw build).
- `i_div`=3, `i_req`=4'b0100 held → `o_gnt`=4'b0100 pulse every 4 cycles; `o_ptr`=3 after the first grant.
- `i_div`=2, `i_req`=0 for 9 cycles, then `i_req`=4'b0001 → no grants while idle. After the request arrives, exactly one grant at the next tick; the three lost slots are not replayed.
- `i_req`=4'b1010, `ptr`=2 → grant 3, then grant 1, then grant 3.
- Assert `i_rst` low in the cycle `o_valid`=1 → all outputs 0 immediately; after release, the first grant goes to the lowest requesting index.
- `RNG_ARB_DECORR_EN` build, `i_div`=0, `i_req`=4'b0010, `i_rng_data`=12'h001 → `o_data`=12'h008.

Source files
------------

// File: rtl/rng_pkg.sv
// Shared constants and types for the LFSR sample-sharing arbiter.
package rng_pkg;

    // Width of one LFSR sample.
    localparam int RNG_DW       = 12;
    // Default number of requesting noise channels.
    localparam int RNG_N_REQ    = 4;
    // Rotate step per winner index for the decorrelating transform.
    localparam int RNG_ROT_STEP = 3;
    // Width of the issue-rate divider.
    localparam int RNG_DIV_W    = 8;

    typedef logic [RNG_DIV_W-1:0] rng_div_t;

endpackage

// File: rtl/rng_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rng_rr_pick
    import rng_pkg::*;
#(
    parameter int N_REQ = RNG_N_REQ,
    parameter int PW    = $clog2(RNG_N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PW-1:0]    ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [PW-1:0]    idx,
    output logic             any
);

    logic [PW-1:0] k;

    // Scan requesters starting at ptr and keep only the first hit.
    always_comb begin
        gnt = '0;
        idx = '0;
        any = 1'b0;
        k   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            k = PW'((int'(ptr) + i) % N_REQ);
            if (!any && req[k]) begin
                any    = 1'b1;
                idx    = k;
                gnt[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rng_share_arb.sv
// Round-robin arbiter sharing one LFSR sample stream among noise channels.
// Optional feature: define RNG_ARB_DECORR_EN to rotate each granted sample
// left by (RNG_ROT_STEP * winner) mod DW; otherwise samples pass through raw.
module rng_share_arb
    import rng_pkg::*;
#(
    parameter int N_REQ = RNG_N_REQ,
    parameter int DW    = RNG_DW
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_en,
    input  logic [RNG_DIV_W-1:0]     i_div,
    input  logic [DW-1:0]            i_rng_data,
    input  logic [N_REQ-1:0]         i_req,
    output logic [N_REQ-1:0]         o_gnt,
    output logic                     o_valid,
    output logic [DW-1:0]            o_data,
    output logic [$clog2(N_REQ)-1:0] o_ptr
);

    localparam int PW = $clog2(N_REQ);

    rng_div_t         div_cnt_p0;
    logic             tick;
    logic             issue;
    logic [N_REQ-1:0] pick_gnt;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;
    logic [DW-1:0]    data_xf;

    logic [PW-1:0]    ptr_p1;
    logic [N_REQ-1:0] gnt_p1;
    logic             vld_p1;
    logic [DW-1:0]    data_p1;

`ifdef RNG_ARB_DECORR_EN
    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d, input int sh);
        if (sh == 0) begin
            return d;
        end
        return (d << sh) | (d >> (DW - sh));
    endfunction
`endif

    // ---- stage 0: issue-slot divider, pick and sample transform ----

    assign tick  = i_en && (div_cnt_p0 >= i_div);
    assign issue = tick && pick_any;

    // Divider free-runs while enabled and restarts on every slot, taken or lost.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            div_cnt_p0 <= '0;
        end else if (!i_en || tick) begin
            div_cnt_p0 <= '0;
        end else begin
            div_cnt_p0 <= div_cnt_p0 + 1'b1;
        end
    end

    rng_rr_pick #(
        .N_REQ (N_REQ),
        .PW    (PW)
    ) u_pick (
        .req (i_req),
        .ptr (ptr_p1),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    // Shape the current sample for whichever channel wins this slot.
    always_comb begin
        data_xf = i_rng_data;
`ifdef RNG_ARB_DECORR_EN
        data_xf = rotl(i_rng_data, (RNG_ROT_STEP * int'(pick_idx)) % DW);
`endif
    end

    // ---- stage 1: registered grant pulse, sample and rotation pointer ----

    // Grant pulse lasts one cycle; data holds between grants; ptr moves past the winner.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            gnt_p1  <= '0;
            vld_p1  <= 1'b0;
            data_p1 <= '0;
            ptr_p1  <= '0;
        end else if (issue) begin
            gnt_p1  <= pick_gnt;
            vld_p1  <= 1'b1;
            data_p1 <= data_xf;
            ptr_p1  <= PW'((int'(pick_idx) + 1) % N_REQ);
        end else begin
            gnt_p1  <= '0;
            vld_p1  <= 1'b0;
        end
    end

    assign o_gnt   = gnt_p1;
    assign o_valid = vld_p1;
    assign o_data  = data_p1;
    assign o_ptr   = ptr_p1;

endmodule

// File: tb/tb_rng_share_arb.sv
// Directed self-checking bench for rng_share_arb (N_REQ=4, DW=12).
module tb_rng_share_arb;

    logic        clk;
    logic        rst;
    logic        en;
    logic [7:0]  div;
    logic [11:0] rng;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic        valid;
    logic [11:0] data;
    logic [1:0]  ptr;

    logic [11:0] prev_rng;
    logic [11:0] last_data;
    int          errors;
    int          checks;

    rng_share_arb #(
        .N_REQ (4),
        .DW    (12)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_en       (en),
        .i_div      (div),
        .i_rng_data (rng),
        .i_req      (req),
        .o_gnt      (gnt),
        .o_valid    (valid),
        .o_data     (data),
        .o_ptr      (ptr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected sample for a given winner, built bit by bit.
    function automatic logic [11:0] exp_data(input logic [11:0] d, input int w);
        logic [11:0] r;
        r = d;
`ifdef RNG_ARB_DECORR_EN
        for (int j = 0; j < 12; j++) begin
            r[(j + 3 * w) % 12] = d[j];
        end
`else
        if (w < 0) r = '0;
`endif
        return r;
    endfunction

    // One clock: remember the sample seen at the edge, then move the LFSR stand-in.
    task automatic step();
        prev_rng = rng;
        @(posedge clk);
        #1;
        rng = rng + 12'h0B7;
    endtask

    initial begin
        errors   = 0;
        checks   = 0;
        rst      = 1'b0;
        en       = 1'b0;
        div      = 8'd0;
        req      = 4'b0000;
        rng      = 12'h5A0;
        prev_rng = 12'h000;
        #1;
        chk("rst_gnt", gnt, 0);
        chk("rst_vld", valid, 0);
        chk("rst_data", data, 0);
        chk("rst_ptr", ptr, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Full load, div 0: rotate every cycle.
        en  = 1'b1;
        div = 8'd0;
        req = 4'b1111;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t1_gnt", gnt, 32'(1 << (k % 4)));
            chk("t1_vld", valid, 1);
            chk("t1_data", data, exp_data(prev_rng, k % 4));
            chk("t1_ptr", ptr, (k + 1) % 4);
        end

        // div 3, single requester: pulse every 4 cycles.
        div = 8'd3;
        req = 4'b0100;
        for (int k = 0; k < 8; k++) begin
            step();
            chk("t2_gnt", gnt, (k % 4 == 3) ? 32'h4 : 32'h0);
            chk("t2_vld", valid, (k % 4 == 3) ? 1 : 0);
            if (k == 3) chk("t2_ptr", ptr, 3);
        end
        last_data = data;

        // div 2, idle: slots lost and not replayed.
        div = 8'd2;
        req = 4'b0000;
        for (int k = 0; k < 9; k++) begin
            step();
            chk("t3_idle_gnt", gnt, 0);
        end
        chk("t3_hold_data", data, last_data);
        req = 4'b0001;
        step();
        chk("t3_wait1", gnt, 0);
        step();
        chk("t3_wait2", gnt, 0);
        step();
        chk("t3_gnt", gnt, 4'b0001);
        chk("t3_ptr", ptr, 1);
        req = 4'b0000;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_after", gnt, 0);
        end

        // Bring ptr to 2, then 1010 alternates 3,1,3.
        div = 8'd0;
        req = 4'b0010;
        step();
        chk("t4_setup", gnt, 4'b0010);
        chk("t4_ptr", ptr, 2);
        req = 4'b1010;
        step();
        chk("t4_g3a", gnt, 4'b1000);
        step();
        chk("t4_g1", gnt, 4'b0010);
        step();
        chk("t4_g3b", gnt, 4'b1000);
        chk("t4_ptr_end", ptr, 0);

        // Enable low blocks grants; rising enable ticks after div cycles.
        en  = 1'b0;
        div = 8'd2;
        req = 4'b1111;
        step();
        chk("t5_dis1", gnt, 0);
        step();
        chk("t5_dis2", gnt, 0);
        en = 1'b1;
        step();
        chk("t5_en1", gnt, 0);
        step();
        chk("t5_en2", gnt, 0);
        step();
        chk("t5_en_gnt", gnt, 4'b0001);
        chk("t5_en_ptr", ptr, 1);

        // Reset while a grant pulse is on the outputs.
        div = 8'd0;
        step();
        chk("t6_pre_vld", valid, 1);
        chk("t6_pre_gnt", gnt, 4'b0010);
        rst = 1'b0;
        #1;
        chk("t6_rst_gnt", gnt, 0);
        chk("t6_rst_vld", valid, 0);
        chk("t6_rst_data", data, 0);
        chk("t6_rst_ptr", ptr, 0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        req = 4'b0110;
        step();
        chk("t6_first_gnt", gnt, 4'b0010);
        chk("t6_first_ptr", ptr, 2);

        // Transform check: requester 1 gets sample 12'h001.
        req = 4'b0010;
        rng = 12'h001;
        step();
        chk("t7_gnt", gnt, 4'b0010);
`ifdef RNG_ARB_DECORR_EN
        chk("t7_data", data, 12'h008);
`else
        chk("t7_data", data, 12'h001);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
